// File: rtl/soc_monitor_pkg.sv
// Shared types for the SoC run monitor: FSM state encoding and the cycle-count type.
package soc_monitor_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_TIMEOUT
    } mon_state_e;

    localparam int CYC_W = 32;
    typedef logic [CYC_W-1:0] cyc_t;

    // Saturating increment; the cycle count must never wrap back to small values.
    function automatic cyc_t sat_inc(cyc_t v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/soc_monitor_channel.sv
// One monitored core: first-rise completion latch, result capture and, when
// MONITOR_STALL_DETECT_EN is defined, an unchanged-fetch-address stall detector.
module soc_monitor_channel #(
    parameter int DATA_W       = 32,
    parameter int STALL_CYCLES = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              run_i,
    input  logic [DATA_W-1:0] flag_i,
    input  logic [DATA_W-1:0] result_i,
    input  logic [DATA_W-1:0] instr_addr_i,
    output logic              done_o,
    output logic              done_nxt_o,
    output logic [DATA_W-1:0] result_o,
    output logic              stall_o
);

    logic              done_q, done_d;
    logic [DATA_W-1:0] result_q, result_d;

    // Only the first flag rise counts; later flag or result activity is ignored.
    always_comb begin
        done_d   = done_q;
        result_d = result_q;
        if (clr_i) begin
            done_d   = 1'b0;
            result_d = '0;
        end else if (run_i && !done_q && (flag_i != '0)) begin
            done_d   = 1'b1;
            result_d = result_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q   <= done_d;
            result_q <= result_d;
        end
    end

    assign done_o     = done_q;
    assign done_nxt_o = done_d;
    assign result_o   = result_q;

`ifdef MONITOR_STALL_DETECT_EN
    localparam int SC_W = $clog2(STALL_CYCLES + 1);

    logic [SC_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [DATA_W-1:0] addr_q;
    logic              stall_q, stall_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stall_d     = stall_q;
        if (clr_i) begin
            stall_cnt_d = '0;
            stall_d     = 1'b0;
        end else begin
            if (done_q || (instr_addr_i != addr_q)) begin
                stall_cnt_d = '0;
            end else if (stall_cnt_q != SC_W'(STALL_CYCLES)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
            if (run_i && (stall_cnt_d == SC_W'(STALL_CYCLES))) begin
                stall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cnt_q <= '0;
            addr_q      <= '0;
            stall_q     <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            addr_q      <= instr_addr_i;
            stall_q     <= stall_d;
        end
    end

    assign stall_o = stall_q;
`else
    logic unused_stall_inputs;
    assign unused_stall_inputs = (^instr_addr_i) ^ (STALL_CYCLES == 0);
    assign stall_o = 1'b0;
`endif

endmodule

// File: rtl/soc_run_monitor.sv
// Program-completion monitor: run/drain/done/timeout FSM over NUM_CH channels.
// Stall detection is compiled in only when MONITOR_STALL_DETECT_EN is defined.
module soc_run_monitor
    import soc_monitor_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int DRAIN_CYCLES   = 1,
    parameter int STALL_CYCLES   = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     start_i,
    input  logic [NUM_CH*DATA_W-1:0] mem_flag_i,
    input  logic [NUM_CH*DATA_W-1:0] mem_result_i,
    input  logic [NUM_CH*DATA_W-1:0] instr_addr_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     timeout_o,
    output logic                     mismatch_o,
    output logic [NUM_CH-1:0]        ch_done_o,
    output logic [DATA_W-1:0]        result_o,
    output logic [31:0]              cycles_o,
    output logic [NUM_CH-1:0]        stall_o
);

    mon_state_e        state_q, state_d;
    cyc_t              cnt_q, cnt_d;
    cyc_t              drain_q, drain_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              mismatch_q, mismatch_d;

    logic [NUM_CH-1:0] ch_done, ch_done_nxt;
    logic [DATA_W-1:0] ch_result [NUM_CH];
    logic              start_ok, run, mm;

    assign start_ok = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                  (state_q == ST_TIMEOUT));
    assign run      = (state_q == ST_RUN);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        soc_monitor_channel #(
            .DATA_W       (DATA_W),
            .STALL_CYCLES (STALL_CYCLES)
        ) u_ch (
            .clk_i        (clk_i),
            .rst_ni       (rst_ni),
            .clr_i        (start_ok),
            .run_i        (run),
            .flag_i       (mem_flag_i[g*DATA_W +: DATA_W]),
            .result_i     (mem_result_i[g*DATA_W +: DATA_W]),
            .instr_addr_i (instr_addr_i[g*DATA_W +: DATA_W]),
            .done_o       (ch_done[g]),
            .done_nxt_o   (ch_done_nxt[g]),
            .result_o     (ch_result[g]),
            .stall_o      (stall_o[g])
        );
    end

    always_comb begin
        mm = 1'b0;
        for (int c = 1; c < NUM_CH; c++) begin
            if (ch_result[c] != ch_result[0]) mm = 1'b1;
        end
    end

    // Completion is tested before timeout so a last flag on the timeout edge wins.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        drain_d    = drain_q;
        result_d   = result_q;
        mismatch_d = mismatch_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                cnt_d = sat_inc(cnt_q);
                if (&ch_done_nxt) begin
                    state_d = ST_DRAIN;
                    drain_d = cyc_t'(DRAIN_CYCLES - 1);
                end else if (cnt_q == cyc_t'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                cnt_d = sat_inc(cnt_q);
                if (drain_q == '0) begin
                    state_d    = ST_DONE;
                    result_d   = ch_result[0];
                    mismatch_d = mm;
                end else begin
                    drain_d = drain_q - 1'b1;
                end
            end
            ST_DONE, ST_TIMEOUT: begin
                if (start_i) begin
                    state_d    = ST_RUN;
                    cnt_d      = '0;
                    drain_d    = '0;
                    result_d   = '0;
                    mismatch_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            drain_q    <= '0;
            result_q   <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            drain_q    <= drain_d;
            result_q   <= result_d;
            mismatch_q <= mismatch_d;
        end
    end

    assign busy_o     = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done_o     = (state_q == ST_DONE);
    assign timeout_o  = (state_q == ST_TIMEOUT);
    assign mismatch_o = mismatch_q;
    assign ch_done_o  = ch_done;
    assign result_o   = result_q;
    assign cycles_o   = cnt_q;

endmodule

// File: tb/tb_soc_run_monitor.sv
// Scoreboard bench for soc_run_monitor (2 channels, timeout 100, drain 3, default build).
module tb_soc_run_monitor;

    localparam int NCH = 2;
    localparam int DW  = 32;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          start_i = 1'b0;
    logic [DW-1:0] flag0 = '0, flag1 = '0, res0 = '0, res1 = '0;
    logic          busy_o, done_o, timeout_o, mismatch_o;
    logic [NCH-1:0] ch_done_o, stall_o;
    logic [DW-1:0] result_o;
    logic [31:0]   cycles_o;

    typedef struct {
        logic        done;
        logic        timeout;
        logic        mismatch;
        logic [31:0] result;
        logic [31:0] cycles;
        logic [1:0]  ch_done;
    } exp_t;

    exp_t exp_q[$];
    int total = 0;
    int bad   = 0;

    soc_run_monitor #(
        .NUM_CH         (NCH),
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (100),
        .DRAIN_CYCLES   (3),
        .STALL_CYCLES   (16)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .mem_flag_i   ({flag1, flag0}),
        .mem_result_i ({res1, res0}),
        .instr_addr_i ({2*DW{1'b0}}),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .timeout_o    (timeout_o),
        .mismatch_o   (mismatch_o),
        .ch_done_o    (ch_done_o),
        .result_o     (result_o),
        .cycles_o     (cycles_o),
        .stall_o      (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     32'(busy_o),     32'd0);
        check({tag, "_done"},     32'(done_o),     32'd0);
        check({tag, "_timeout"},  32'(timeout_o),  32'd0);
        check({tag, "_mismatch"}, 32'(mismatch_o), 32'd0);
        check({tag, "_ch_done"},  32'(ch_done_o),  32'd0);
        check({tag, "_result"},   result_o,        32'd0);
        check({tag, "_cycles"},   cycles_o,        32'd0);
        check({tag, "_stall"},    32'(stall_o),    32'd0);
    endtask

    // Monitor: on every rising finish indication, pop and compare the expected outcome.
    initial begin
        bit   prev;
        exp_t x;
        prev = 1'b0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                prev = 1'b0;
            end else begin
                if ((done_o || timeout_o) && !prev) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_finish: done=%0b timeout=%0b with nothing expected",
                                 done_o, timeout_o);
                    end else begin
                        x = exp_q.pop_front();
                        check("fin_done",     32'(done_o),     32'(x.done));
                        check("fin_timeout",  32'(timeout_o),  32'(x.timeout));
                        check("fin_mismatch", 32'(mismatch_o), 32'(x.mismatch));
                        check("fin_result",   result_o,        x.result);
                        check("fin_cycles",   cycles_o,        x.cycles);
                        check("fin_ch_done",  32'(ch_done_o),  32'(x.ch_done));
                        check("fin_stall",    32'(stall_o),    32'd0);
                    end
                end
                prev = done_o || timeout_o;
            end
        end
    end

    // Edge e = e-th rising edge after the start edge; 0 means the flag never rises.
    task automatic run_case(input int e0, input int r0, input int e1, input int r1, input bit toggle);
        bit         fin_ok;
        int         last;
        exp_t       x;
        logic [1:0] cd;
        fin_ok     = (e0 != 0) && (e1 != 0) && (e0 <= 100) && (e1 <= 100);
        last       = fin_ok ? ((e0 > e1) ? e0 : e1) : 100;
        x.done     = fin_ok;
        x.timeout  = !fin_ok;
        x.mismatch = fin_ok && (r0 != r1);
        x.result   = fin_ok ? 32'(r0) : 32'd0;
        x.cycles   = fin_ok ? 32'(last + 3) : 32'd100;
        x.ch_done  = {(e1 != 0) && (e1 <= last), (e0 != 0) && (e0 <= last)};
        exp_q.push_back(x);

        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        for (int e = 1; e <= last; e++) begin
            if (e == e0) begin
                flag0 = 32'd1;
                res0  = 32'(r0);
            end else if (toggle && e > e0) begin
                flag0 = {31'd0, e[0]};
                res0  = 32'(r0 + e);
            end
            if (e == e1) begin
                flag1 = 32'd1;
                res1  = 32'(r1);
            end
            start_i = toggle && (e == 3);
            @(posedge clk_i);
            @(negedge clk_i);
            cd = {(e1 != 0) && (e1 <= e), (e0 != 0) && (e0 <= e)};
            check("run_ch_done", 32'(ch_done_o), 32'(cd));
            check("run_busy",    32'(busy_o),    32'(fin_ok || (e < 100)));
        end
        start_i = 1'b0;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk_i);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL finish_wait: no done/timeout within 20 cycles (done=%0b timeout=%0b)",
                     done_o, timeout_o);
            exp_q.delete();
        end
        repeat (4) @(negedge clk_i);
        check("sticky_done",    32'(done_o),    32'(x.done));
        check("sticky_timeout", 32'(timeout_o), 32'(x.timeout));
        flag0 = '0;
        flag1 = '0;
        res0  = '0;
        res1  = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk_i);
        check_all_zero("reset");
        rst_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        check_all_zero("idle");

        run_case(40, 55, 40, 55, 1'b0);   // both at once
        run_case(10, 55, 30, 55, 1'b0);   // staggered, 01 then 11
        run_case(12, 55, 20, 54, 1'b0);   // result mismatch
        run_case(0,  0,  0,  0,  1'b0);   // pure timeout
        run_case(40, 7,  100, 7, 1'b0);   // last flag on timeout edge
        run_case(50, 9,  0,  0,  1'b0);   // partial completion then timeout

        // Abort mid-drain with asynchronous reset.
        start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        flag0 = 32'd1; flag1 = 32'd1; res0 = 32'd5; res1 = 32'd6;
        @(posedge clk_i);
        @(posedge clk_i);
        #2 check("drain_busy", 32'(busy_o), 32'd1);
        rst_ni = 1'b0;
        #1 check_all_zero("async_rst");
        flag0 = '0; flag1 = '0; res0 = '0; res1 = '0;
        @(negedge clk_i);
        rst_ni = 1'b1;
        repeat (2) @(negedge clk_i);
        check_all_zero("post_rst");

        run_case(5, 77, 15, 77, 1'b1);    // toggling flag/result and ignored start in RUN

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/soc_run_monitor.md
Name: soc_run_monitor

Overview:
- Synthesizable, parametrised program-completion monitor for multi-core SoC variants.
- Replaces bench-only flag polling and timeout logic with a reusable block.
- Watches NUM_CH cores' memory-mapped completion flag and result words and latches each channel's result on its first flag rise.
- After a drain delay, reports done / timeout / cross-channel result mismatch. Sits beside the data memory, usable in silicon and in simulation.

Parameters:
- NUM_CH, 2, number of monitored cores/channels (>=1)
- DATA_W, 32, width of flag, result and instruction-address words
- TIMEOUT_CYCLES, 1000, RUN cycles allowed before timeout (>=2)
- DRAIN_CYCLES, 1, cycles waited after last flag before done (>=1)
- STALL_CYCLES, 16, unchanged-PC cycles flagged as stall (optional feature only)

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  start/restart pulse (fetch-enable equivalent)
- mem_flag_i  in  NUM_CH*DATA_W  per-channel completion flag word; nonzero = finished
- mem_result_i  in  NUM_CH*DATA_W  per-channel result word
- instr_addr_i  in  NUM_CH*DATA_W  per-channel fetch address
- busy_o  out  1  high in RUN or DRAIN
- done_o  out  1  all channels finished, drain elapsed (sticky)
- timeout_o  out  1  TIMEOUT_CYCLES elapsed without completion (sticky)
- mismatch_o  out  1  valid with done_o; a channel result differs from channel 0
- ch_done_o  out  NUM_CH  per-channel latched-finish bits
- result_o  out  DATA_W  latched result of channel 0
- cycles_o  out  32  RUN cycle count, frozen at DONE/TIMEOUT
- stall_o  out  NUM_CH  per-channel stall flags (tied 0 without feature)

Behaviour:
- Reset (async, rst_ni low): state IDLE; every output 0; internal result registers 0. Reset mid-operation aborts immediately to IDLE with no output residue.
- States: IDLE, RUN, DRAIN, DONE, TIMEOUT.
- IDLE: start_i high at edge s -> RUN; cycle counter = 0; ch_done cleared.
- DONE or TIMEOUT: start_i -> RUN, clearing done_o, timeout_o, mismatch_o, ch_done_o, result registers and counters.
- RUN/DRAIN: start_i is ignored.
- RUN, each edge:
  - Counter increments.
  - For each channel with ch_done bit clear and mem_flag nonzero: set the bit and latch mem_result into that channel's register.
  - First rise only; later flag/result changes are ignored.
- All bits set after edge k -> DRAIN at edge k; drain counter loaded with DRAIN_CYCLES-1.
- DRAIN: decrement each edge; at 0 -> DONE. done_o is high after edge k+DRAIN_CYCLES. The cycle counter keeps counting through DRAIN.
- Timeout: in RUN, counter == TIMEOUT_CYCLES-1 at an edge with any bit still clear -> TIMEOUT; cycles_o = TIMEOUT_CYCLES.
- Simultaneous: last flag latched on the timeout edge -> completion wins (DRAIN, no timeout). DRAIN never times out.
- On entry to DONE:
  - result_o = channel 0 register.
  - mismatch_o = OR over ch>=1 of (reg[ch] != reg[0]); always 0 when NUM_CH=1.
  - cycles_o = counter value.
- DONE/TIMEOUT are sticky until start_i or reset.
- Counter width 32; saturates at all-ones, no wrap.

Optional Feature:
- Macro: MONITOR_STALL_DETECT_EN.
- Defined: per-channel counter resets whenever instr_addr changes or the channel is done. While in RUN, reaching STALL_CYCLES sets the sticky stall_o bit, cleared on start_i or reset.
- Stall does not change the state machine.
- Undefined: no counters instantiated; stall_o tied 0.

Decomposition:
- Package soc_monitor_pkg: state enum (IDLE, RUN, DRAIN, DONE, TIMEOUT) and the 32-bit cycle-count type.
- Sub-module soc_monitor_channel per channel: first-rise flag latch, result register and optional stall counter. Instantiated NUM_CH times via generate.
- Top holds the FSM, counters and mismatch reduction.

Test Plan:
- NUM_CH=1, DRAIN_CYCLES=1: start, flag=1 with result=55 at RUN cycle 40 -> done_o one edge later, result_o=55, mismatch_o=0, timeout_o=0.
- NUM_CH=2: ch0 flag at cycle 10 result=55, ch1 at cycle 30 result=55 -> ch_done_o 01 then 11; done_o after drain; mismatch_o=0; cycles_o=31.
- NUM_CH=2: results 55 and 54 -> done_o=1, mismatch_o=1, result_o=55.
- TIMEOUT_CYCLES=100, no flags -> timeout_o=1 at RUN edge 100, cycles_o=100, done_o=0. Separately, last flag on edge 100 -> done_o, no timeout.
- Reset asserted mid-DRAIN -> all outputs 0 asynchronously. Restart with start_i -> clean run. Flag toggled 0->1->0->1 with changing result -> first latched value kept.
- MONITOR_STALL_DETECT_EN, STALL_CYCLES=16: hold instr_addr constant 16 cycles on ch1 -> stall_o=10. Without the macro -> stall_o=00.
